// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between writeback sources.
// Optional busy-bit scoreboard built when RF_WB_SCOREBOARD_EN is defined.
`timescale 1ns/1ps
module rf_wb_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_wdata,
    output logic [2:0]           grant_id,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic [AW-1:0]        q_rs,
    input  logic [AW-1:0]        q_rt,
    output logic                 busy_rs,
    output logic                 busy_rt
);

    localparam int unsigned GW   = 3;
    localparam int unsigned NREG = 1 << AW;

    logic [GW-1:0]   ptr_q, ptr_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;

    logic [NREQ-1:0] grant_c;
    logic            xfer_c;
    logic [GW-1:0]   gid_c;
    logic [AW-1:0]   sel_addr_c;
    logic [DW-1:0]   sel_data_c;
    int unsigned     idx;

    // Round-robin search from ptr; no grant while stalled or in reset.
    always_comb begin
        grant_c    = '0;
        xfer_c     = 1'b0;
        gid_c      = '0;
        sel_addr_c = '0;
        sel_data_c = '0;
        idx        = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!xfer_c && rst && !stall && req_valid[idx]) begin
                xfer_c       = 1'b1;
                grant_c[idx] = 1'b1;
                gid_c        = GW'(idx);
                sel_addr_c   = req_addr[idx*AW +: AW];
                sel_data_c   = req_data[idx*DW +: DW];
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        grant_id_d = grant_id_q;
        if (xfer_c) begin
            ptr_d      = (32'(gid_c) == NREQ - 1) ? '0 : gid_c + GW'(1);
            rf_we_d    = |sel_addr_c;
            rf_waddr_d = sel_addr_c;
            rf_wdata_d = sel_data_c;
            grant_id_d = gid_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            grant_id_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign req_ready = grant_c;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign grant_id  = grant_id_q;

`ifdef RF_WB_SCOREBOARD_EN
    logic [NREG-1:0] busy_q, busy_d;

    // Commit clears, issue sets; set applied last so it wins on a collision.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_rs = busy_q[q_rs];
    assign busy_rt = busy_q[q_rt];
`else
    logic unused_c;
    assign unused_c = ^{iss_valid, iss_rd, q_rs, q_rt};
    assign busy_rs  = 1'b0;
    assign busy_rt  = 1'b0;
`endif

endmodule
